// File: rtl/write_buffer.sv
// Write-through store buffer between the data cache and main memory.
// In-order drain over req/ack, store merging, and read-miss forwarding.
module write_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf,
  input  logic [ADDR_W-1:0]            lk_addr,
  output logic                         lk_hit,
  output logic [DATA_W-1:0]            lk_data,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_data,
  input  logic                         mem_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
  state_t state;

  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic              merge_hit;
  logic [PTR_W-1:0]  merge_idx;
  logic              push_alloc;
  logic              push_drop;
  logic              pop;
  logic              nf_hit;
  logic              hd_hit;
  logic [DATA_W-1:0] nf_data;
  logic [DATA_W-1:0] hd_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0) && (state == IDLE);

  // The head entry is "in flight" only while REQ is active; it never merges.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr_q[i] == wr_addr) &&
          !((state == REQ) && (PTR_W'(i) == head))) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
  end

  assign push_alloc = wr_en && !merge_hit && !full;
  assign push_drop  = wr_en && !merge_hit && full;
  assign pop        = (state == REQ) && mem_ack;

  // A not-in-flight match is always younger than the in-flight head.
  always_comb begin
    nf_hit  = 1'b0;
    hd_hit  = 1'b0;
    nf_data = '0;
    hd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr_q[i] == lk_addr)) begin
        if ((state == REQ) && (PTR_W'(i) == head)) begin
          hd_hit  = 1'b1;
          hd_data = data_q[i];
        end else begin
          nf_hit  = 1'b1;
          nf_data = data_q[i];
        end
      end
    end
  end

  assign lk_hit  = nf_hit || hd_hit;
  assign lk_data = nf_hit ? nf_data : (hd_hit ? hd_data : '0);

  // Handshake: mem_req rises with mem_addr/mem_data already valid and holds them
  // frozen until a cycle with mem_ack=1; that edge completes the write and
  // drops mem_req for at least one cycle. mem_ack outside REQ is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      ovf <= push_drop;

      if (wr_en && merge_hit) begin
        data_q[merge_idx] <= wr_data;
      end

      if (push_alloc) begin
        valid[tail]  <= 1'b1;
        addr_q[tail] <= wr_addr;
        data_q[tail] <= wr_data;
        tail         <= tail + 1'b1;
      end

      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end

      count <= count + CNT_W'(push_alloc) - CNT_W'(pop);

      case (state)
        IDLE: begin
          if (count != '0) begin
            mem_addr <= addr_q[head];
            // A merge into the head on this same edge must not be lost.
            mem_data <= (wr_en && merge_hit && (merge_idx == head)) ? wr_data
                                                                    : data_q[head];
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: reset checks, a cycle-by-cycle vector table with
// lookup/flag expectations, hand sequences for ack timing, mid-transfer reset and wrap.
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        ovf;
  logic [31:0] lk_addr;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        auto_ack;
  logic        man_ack;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        ack;
    logic [31:0] lk;
    int          cnt;
    logic        full;
    logic        ovf;
    logic        req;
    logic        hit;
    logic [31:0] lkd;
    int          sb;   // 0 none, 1 new drain entry, 2 data merged into queued entry
  } vec_t;

  vec_t vt[17];

  always #5 clk = ~clk;

  assign mem_ack = auto_ack ? mem_req : man_ack;

  write_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .ovf(ovf),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ack(mem_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completed memory writes are checked against the expected drain order.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL drain_unexpected: got %0h expected none", {mem_addr, mem_data});
      end else begin
        chk("drain", {mem_addr, mem_data}, exp_q.pop_front());
      end
    end
  end

  task automatic drain_wait(input string tag);
    int c = 0;
    while (!(empty && exp_q.size() == 0) && c < 200) begin
      step();
      c++;
    end
    chk($sformatf("%s_empty", tag), 64'(empty), 64'd1);
    chk($sformatf("%s_count", tag), 64'(count), 64'd0);
    chk($sformatf("%s_pending", tag), 64'(exp_q.size()), 64'd0);
  endtask

  task automatic sb_apply(input int sb, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] tmp;
    if (sb == 1) exp_q.push_back({a, d});
    if (sb == 2) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        tmp = exp_q[i];
        if (tmp[63:32] == a) begin
          exp_q[i] = {a, d};
          break;
        end
      end
    end
  endtask

  initial begin
    //       wr    addr    data       ack   lk      cnt full  ovf   req   hit   lkd        sb
    vt[0]  = '{1'b1, 32'h20, 32'hA0,   1'b0, 32'h20, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0,   1};
    vt[1]  = '{1'b1, 32'h24, 32'hA4,   1'b0, 32'h24, 2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA4,   1};
    vt[2]  = '{1'b1, 32'h28, 32'hA8,   1'b0, 32'h20, 3, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0,   1};
    vt[3]  = '{1'b1, 32'h2C, 32'hAC,   1'b0, 32'h2C, 4, 1'b1, 1'b0, 1'b1, 1'b1, 32'hAC,   1};
    vt[4]  = '{1'b1, 32'h30, 32'hB0,   1'b0, 32'h30, 4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    0};
    vt[5]  = '{1'b1, 32'h24, 32'hBEEF, 1'b0, 32'h24, 4, 1'b1, 1'b0, 1'b1, 1'b1, 32'hBEEF, 2};
    vt[6]  = '{1'b0, 32'h0,  32'h0,    1'b0, 32'h24, 4, 1'b1, 1'b0, 1'b1, 1'b1, 32'hBEEF, 0};
    vt[7]  = '{1'b1, 32'h34, 32'hC4,   1'b1, 32'h34, 3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    0};
    vt[8]  = '{1'b0, 32'h0,  32'h0,    1'b0, 32'h20, 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    0};
    vt[9]  = '{1'b1, 32'h24, 32'h55,   1'b0, 32'h24, 4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55,   1};
    vt[10] = '{1'b0, 32'h0,  32'h0,    1'b1, 32'h24, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55,   0};
    vt[11] = '{1'b0, 32'h0,  32'h0,    1'b0, 32'h28, 3, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA8,   0};
    vt[12] = '{1'b0, 32'h0,  32'h0,    1'b1, 32'h28, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    0};
    vt[13] = '{1'b0, 32'h0,  32'h0,    1'b0, 32'h2C, 2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAC,   0};
    vt[14] = '{1'b1, 32'h38, 32'hC8,   1'b1, 32'h38, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC8,   1};
    vt[15] = '{1'b0, 32'h0,  32'h0,    1'b1, 32'h38, 2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC8,   0};
    vt[16] = '{1'b0, 32'h0,  32'h0,    1'b0, 32'h24, 2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55,   0};

    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    lk_addr  = '0;
    auto_ack = 1'b0;
    man_ack  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req",   64'(mem_req),  64'd0);
    chk("rst_count", 64'(count),    64'd0);
    chk("rst_empty", 64'(empty),    64'd1);
    chk("rst_full",  64'(full),     64'd0);
    chk("rst_ovf",   64'(ovf),      64'd0);
    chk("rst_addr",  64'(mem_addr), 64'd0);
    chk("rst_hit",   64'(lk_hit),   64'd0);
    rst_n = 1'b1;
    step();

    // Single store, ack one cycle after the request rises
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h11;
    sb_apply(1, 32'h10, 32'h11);
    step();
    wr_en = 1'b0;
    chk("t2_count1", 64'(count),   64'd1);
    chk("t2_noreq",  64'(mem_req), 64'd0);
    chk("t2_nempty", 64'(empty),   64'd0);
    step();
    chk("t2_req",  64'(mem_req),  64'd1);
    chk("t2_addr", 64'(mem_addr), 64'h10);
    chk("t2_data", 64'(mem_data), 64'h11);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    chk("t2_count0", 64'(count),   64'd0);
    chk("t2_empty",  64'(empty),   64'd1);
    chk("t2_reqlow", 64'(mem_req), 64'd0);

    // Vector table: fill, overflow, merge, in-flight head, push+ack, ack in IDLE
    for (int v = 0; v < 17; v++) begin
      wr_en   = vt[v].wr;
      wr_addr = vt[v].a;
      wr_data = vt[v].d;
      man_ack = vt[v].ack;
      lk_addr = vt[v].lk;
      sb_apply(vt[v].sb, vt[v].a, vt[v].d);
      step();
      chk($sformatf("v%0d_count", v), 64'(count),   64'(vt[v].cnt));
      chk($sformatf("v%0d_full", v),  64'(full),    64'(vt[v].full));
      chk($sformatf("v%0d_ovf", v),   64'(ovf),     64'(vt[v].ovf));
      chk($sformatf("v%0d_req", v),   64'(mem_req), 64'(vt[v].req));
      chk($sformatf("v%0d_empty", v), 64'(empty),   64'd0);
      chk($sformatf("v%0d_hit", v),   64'(lk_hit),  64'(vt[v].hit));
      chk($sformatf("v%0d_lkd", v),   64'(lk_data), 64'(vt[v].lkd));
    end
    wr_en   = 1'b0;
    man_ack = 1'b0;
    auto_ack = 1'b1;
    drain_wait("table_drain");
    auto_ack = 1'b0;

    // Reset asserted mid-REQ, between clock edges
    wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'h44;
    step();
    wr_en = 1'b0;
    step();
    chk("t6_req_before", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_async",   64'(mem_req), 64'd0);
    chk("t6_count_async", 64'(count),   64'd0);
    chk("t6_empty_async", 64'(empty),   64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_empty_after", 64'(empty), 64'd1);

    // Eight stores across pointer wrap, drained with immediate ack
    auto_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 32'h100 + 32'(i * 4);
      wr_data = $urandom;
      sb_apply(1, wr_addr, wr_data);
      step();
      wr_en = 1'b0;
      step();
    end
    drain_wait("wrap_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
